// File: rtl/seq_detect_stream_ctrl.sv
// seq_detect_stream_ctrl: accepts parallel words over valid/ready, serializes
// them MSB-first one bit per cycle, and runs an overlapping pattern matcher
// with a saturating match counter and a sticky threshold interrupt.
module seq_detect_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic [PAT_W-1:0]  cfg_pattern_i,
    input  logic [CNT_W-1:0]  cfg_threshold_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              bit_out_o,
    output logic              bit_valid_o,
    output logic              detected_o,
    output logic [CNT_W-1:0]  match_count_o,
    output logic              irq_o,
    output logic              busy_o
);

    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  word_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   hist_q;
    logic [PAT_W-1:0]   hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               det_q;
    logic               irq_q;
    logic               last_bit;
    logic               accept;
    logic               match;

    // The word register shifts left, so the bit on the wire is always its MSB.
    assign last_bit    = (state_q == SHIFT) && (idx_q == IDX_W'(DATA_W - 1));
    assign in_ready_o  = enable_i && ((state_q == RUN) || last_bit);
    assign accept      = in_valid_i && in_ready_o;
    assign bit_valid_o = (state_q == SHIFT);
    assign bit_out_o   = bit_valid_o & word_q[DATA_W-1];
    assign busy_o      = (state_q != IDLE);

    // History including the bit on the wire; a match needs PAT_W real bits.
    assign hist_d  = {hist_q[PAT_W-2:0], bit_out_o};
    assign match   = bit_valid_o && (hist_d == pat_q) && (fill_q >= FILL_W'(PAT_W - 1));
    assign cnt_inc = cnt_q + CNT_W'(1);

    assign detected_o    = det_q;
    assign match_count_o = cnt_q;
    assign irq_o         = irq_q;

    // Control FSM: latch pattern on start, accept words, serialize without bubbles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        pat_q   <= cfg_pattern_i;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        word_q  <= in_data_i;
                        idx_q   <= '0;
                        state_q <= SHIFT;
                    end else if (!enable_i) begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        if (accept) begin
                            // next word starts on the very next cycle
                            word_q <= in_data_i;
                            idx_q  <= '0;
                        end else begin
                            word_q  <= word_q << 1;
                            state_q <= enable_i ? RUN : IDLE;
                        end
                    end else begin
                        // enable is not consulted here: a word in flight always completes
                        word_q <= word_q << 1;
                        idx_q  <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Matcher: history/fill tracking, registered match pulse, counter and irq.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            det_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else if (clear_i) begin
            // clear beats a coincident match and drops the bit on the wire
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            det_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            det_q <= match;
            if (bit_valid_o) begin
                hist_q <= hist_d;
                if (fill_q < FILL_W'(PAT_W)) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end
            if (match && !(&cnt_q)) begin
                cnt_q <= cnt_inc;
                if ((cfg_threshold_i != '0) && (cnt_inc == cfg_threshold_i)) begin
                    irq_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_stream_ctrl.sv
// Bench for seq_detect_stream_ctrl: directed scenarios with constant
// expectations plus randomized streams checked against a bit-list model.
module tb_seq_detect_stream_ctrl;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int CW = 8;
    localparam int NW = 12;
    localparam int HMAX = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] cfg_pattern = '0;
    logic [CW-1:0] cfg_threshold = '0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready, bit_out, bit_valid, detected, irq, busy;
    logic [CW-1:0] match_count;
    logic          in_ready_s, bit_out_s, bit_valid_s, detected_s, irq_s, busy_s;
    logic [1:0]    match_count_s;

    int npass = 0;
    int ntot  = 0;

    logic          drv_v   [64];
    logic          drv_en  [64];
    logic          drv_clr [64];
    logic [DW-1:0] drv_d   [64];
    logic [63:0]   m_bv, m_det, m_rdy, m_busy, m_irq, bits;
    int            o_cnt  [64];
    int            o_cnts [64];

    seq_detect_stream_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) u_dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear),
        .cfg_pattern_i(cfg_pattern), .cfg_threshold_i(cfg_threshold),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .bit_out_o(bit_out), .bit_valid_o(bit_valid), .detected_o(detected),
        .match_count_o(match_count), .irq_o(irq), .busy_o(busy)
    );

    // Narrow-counter copy on the same stimulus, used for saturation checks.
    seq_detect_stream_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(2)) u_sat (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear),
        .cfg_pattern_i(cfg_pattern), .cfg_threshold_i(cfg_threshold[1:0]),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_s),
        .bit_out_o(bit_out_s), .bit_valid_o(bit_valid_s), .detected_o(detected_s),
        .match_count_o(match_count_s), .irq_o(irq_s), .busy_o(busy_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_drv();
        for (int i = 0; i < 64; i++) begin
            drv_v[i]   = 1'b0;
            drv_en[i]  = 1'b1;
            drv_clr[i] = 1'b0;
            drv_d[i]   = DW'($urandom);
        end
    endtask

    // Drain, clear the matcher and start: on return the DUT is in RUN, so a
    // word presented in the current cycle is accepted in it (cycle 0).
    task automatic start(input logic [PW-1:0] pat);
        enable   = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (DW + 2) tick();
        cfg_pattern = pat;
        clear       = 1'b1;
        enable      = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Replay the drv_* tables for n cycles and record outputs mid-cycle.
    task automatic run_cap(input int n);
        m_bv = '0; m_det = '0; m_rdy = '0; m_busy = '0; m_irq = '0; bits = '0;
        for (int i = 0; i < n; i++) begin
            in_valid = drv_v[i];
            in_data  = drv_d[i];
            enable   = drv_en[i];
            clear    = drv_clr[i];
            @(negedge clk);
            m_bv[i]   = bit_valid;
            if (bit_valid) bits = {bits[62:0], bit_out};
            m_det[i]  = detected;
            m_rdy[i]  = in_ready;
            m_busy[i] = busy;
            m_irq[i]  = irq;
            o_cnt[i]  = int'(match_count);
            o_cnts[i] = int'(match_count_s);
            tick();
        end
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        ntot++;
        if ({busy, in_ready, bit_valid, bit_out, detected, irq} !== 6'b0 || match_count !== '0 || match_count_s !== '0)
            $display("FAIL reset_outputs: busy=%b rdy=%b bv=%b bit=%b det=%b irq=%b cnt=%0d, want all 0",
                     busy, in_ready, bit_valid, bit_out, detected, irq, match_count);
        else npass++;
        enable = 1'b1;
        tick();
        @(negedge clk);
        ntot++;
        if (busy !== 1'b0) $display("FAIL reset_hold_idle: busy=%b want 0", busy);
        else npass++;
        tick();
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_overlap();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'h6D;
        start(4'b1101);
        run_cap(12);
        ntot++;
        if (m_bv !== 64'h1FE) $display("FAIL overlap_bv: got %h want %h", m_bv, 64'h1FE);
        else npass++;
        ntot++;
        if (bits[7:0] !== 8'h6D) $display("FAIL overlap_bits: got %h want 6d", bits[7:0]);
        else npass++;
        ntot++;
        if (m_det !== 64'h240) $display("FAIL overlap_det: got %h want %h", m_det, 64'h240);
        else npass++;
        ntot++;
        if (o_cnt[11] !== 2) $display("FAIL overlap_cnt: got %0d want 2", o_cnt[11]);
        else npass++;
    endtask

    task automatic test_back_to_back();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'h0D;
        for (int i = 1; i <= 8; i++) begin
            drv_v[i] = 1'b1; drv_d[i] = 8'hA0;
        end
        start(4'b1101);
        run_cap(18);
        ntot++;
        if (m_bv !== 64'h1FFFE) $display("FAIL b2b_bv: got %h want %h", m_bv, 64'h1FFFE);
        else npass++;
        ntot++;
        if (bits[15:0] !== 16'h0DA0) $display("FAIL b2b_bits: got %h want 0da0", bits[15:0]);
        else npass++;
        ntot++;
        if (m_rdy[8] !== 1'b1 || m_rdy[4] !== 1'b0)
            $display("FAIL b2b_ready: rdy@8=%b rdy@4=%b want 1,0", m_rdy[8], m_rdy[4]);
        else npass++;
        ntot++;
        if (m_det !== 64'h1200) $display("FAIL b2b_det: got %h want %h", m_det, 64'h1200);
        else npass++;
        ntot++;
        if (o_cnt[17] !== 2) $display("FAIL b2b_cnt: got %0d want 2", o_cnt[17]);
        else npass++;
    endtask

    task automatic test_threshold();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'hDD;
        for (int i = 1; i <= 8; i++) begin
            drv_v[i] = 1'b1; drv_d[i] = 8'hD0;
        end
        cfg_threshold = 8'd3;
        start(4'b1101);
        run_cap(20);
        ntot++;
        if (m_det !== 64'h2220) $display("FAIL thr_det: got %h want %h", m_det, 64'h2220);
        else npass++;
        ntot++;
        if (o_cnt[5] !== 1 || o_cnt[9] !== 2 || o_cnt[13] !== 3)
            $display("FAIL thr_cnt_steps: got %0d,%0d,%0d want 1,2,3", o_cnt[5], o_cnt[9], o_cnt[13]);
        else npass++;
        ntot++;
        if (m_irq[19:0] !== 20'hFE000) $display("FAIL thr_irq: got %h want fe000", m_irq[19:0]);
        else npass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        ntot++;
        if (irq !== 1'b0 || match_count !== '0)
            $display("FAIL thr_clear: irq=%b cnt=%0d want 0,0", irq, match_count);
        else npass++;
        tick();
        cfg_threshold = '0;
    endtask

    task automatic test_fill_guard();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'h00;
        start(4'b0000);
        run_cap(13);
        ntot++;
        if (m_det !== 64'h3E0) $display("FAIL fill_det: got %h want %h", m_det, 64'h3E0);
        else npass++;
        ntot++;
        if (o_cnt[12] !== 5) $display("FAIL fill_cnt: got %0d want 5", o_cnt[12]);
        else npass++;
    endtask

    task automatic test_saturation();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'hFF;
        start(4'b1111);
        run_cap(12);
        ntot++;
        if (m_det !== 64'h3E0) $display("FAIL sat_det: got %h want %h", m_det, 64'h3E0);
        else npass++;
        ntot++;
        if (o_cnt[11] !== 5) $display("FAIL sat_wide_cnt: got %0d want 5", o_cnt[11]);
        else npass++;
        ntot++;
        if (o_cnts[6] !== 2 || o_cnts[7] !== 3 || o_cnts[11] !== 3)
            $display("FAIL sat_narrow_cnt: got %0d,%0d,%0d want 2,3,3", o_cnts[6], o_cnts[7], o_cnts[11]);
        else npass++;
    endtask

    task automatic test_clear_priority();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            drv_v[i] = 1'b1; drv_d[i] = 8'hFF;
        end
        drv_clr[6] = 1'b1;
        start(4'b1111);
        run_cap(20);
        ntot++;
        if (m_det !== 64'h3F860) $display("FAIL clrpri_det: got %h want %h", m_det, 64'h3F860);
        else npass++;
        ntot++;
        if (o_cnt[6] !== 2 || o_cnt[7] !== 0)
            $display("FAIL clrpri_cnt_zero: got %0d,%0d want 2,0", o_cnt[6], o_cnt[7]);
        else npass++;
        ntot++;
        if (o_cnt[19] !== 7 || o_cnts[19] !== 3)
            $display("FAIL clrpri_cnt_end: got %0d/%0d want 7/3", o_cnt[19], o_cnts[19]);
        else npass++;
    endtask

    task automatic test_enable_drop();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'h6D;
        for (int i = 3; i < 64; i++) drv_en[i] = 1'b0;
        start(4'b1101);
        run_cap(12);
        ntot++;
        if (m_bv !== 64'h1FE || bits[7:0] !== 8'h6D)
            $display("FAIL endrop_bits: bv=%h bits=%h want 1fe,6d", m_bv, bits[7:0]);
        else npass++;
        ntot++;
        if (m_busy !== 64'h1FF) $display("FAIL endrop_busy: got %h want 1ff", m_busy);
        else npass++;
        ntot++;
        if (m_rdy !== 64'h1) $display("FAIL endrop_ready: got %h want 1", m_rdy);
        else npass++;
    endtask

    task automatic test_reset_midword();
        clr_drv();
        drv_v[0] = 1'b1; drv_d[0] = 8'h6D;
        start(4'b0110);
        run_cap(5);
        ntot++;
        if (detected !== 1'b1 || match_count !== 8'd1 || bit_valid !== 1'b1)
            $display("FAIL rstmid_pre: det=%b cnt=%0d bv=%b want 1,1,1", detected, match_count, bit_valid);
        else npass++;
        reset = 1'b1;
        #1;
        ntot++;
        if ({busy, in_ready, bit_valid, bit_out, detected, irq} !== 6'b0 || match_count !== '0)
            $display("FAIL rstmid_async: busy=%b rdy=%b bv=%b bit=%b det=%b irq=%b cnt=%0d want all 0",
                     busy, in_ready, bit_valid, bit_out, detected, irq, match_count);
        else npass++;
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        ntot++;
        if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rstmid_idle: busy=%b rdy=%b want 0,0", busy, in_ready);
        else npass++;
        tick();
    endtask

    // Random words with random gaps; expectations come from the acceptance
    // rule (accept at max(offer, previous accept + DW)) and a list of emitted bits.
    task automatic test_random();
        int            a [NW];
        logic [DW-1:0] w [NW];
        logic          ev [HMAX];
        logic          eb [HMAX];
        logic          ed [HMAX];
        logic          dv [HMAX];
        logic [DW-1:0] dd [HMAX];
        int            hb [$];
        int            s, h, val, ecnt, ecnts, thr;
        logic          eirq;
        logic [PW-1:0] pat;

        pat = PW'($urandom);
        thr = int'($urandom_range(1, 6));
        for (int c = 0; c < HMAX; c++) begin
            ev[c] = 1'b0; eb[c] = 1'b0; ed[c] = 1'b0; dv[c] = 1'b0; dd[c] = DW'($urandom);
        end
        s = 0;
        for (int j = 0; j < NW; j++) begin
            w[j] = DW'($urandom);
            if (j == 0) a[j] = s;
            else a[j] = (s > a[j-1] + DW) ? s : a[j-1] + DW;
            for (int c = s; c <= a[j]; c++) begin
                dv[c] = 1'b1; dd[c] = w[j];
            end
            for (int k = 0; k < DW; k++) begin
                ev[a[j]+1+k] = 1'b1;
                eb[a[j]+1+k] = w[j][DW-1-k];
            end
            s = a[j] + 1 + int'($urandom_range(0, 12));
        end
        h = a[NW-1] + DW + 4;
        for (int c = 0; c < h; c++) begin
            if (ev[c]) begin
                hb.push_back(int'(eb[c]));
                if (hb.size() >= PW) begin
                    val = 0;
                    for (int i = 0; i < PW; i++) val = val * 2 + hb[hb.size()-PW+i];
                    if (val == int'(pat)) ed[c+1] = 1'b1;
                end
            end
        end

        cfg_threshold = CW'(thr);
        start(pat);
        ecnt = 0; ecnts = 0; eirq = 1'b0;
        for (int c = 0; c < h; c++) begin
            in_valid = dv[c];
            in_data  = dd[c];
            @(negedge clk);
            if (ed[c]) begin
                if (ecnt < 255) ecnt++;
                if (ecnt == thr) eirq = 1'b1;
                if (ecnts < 3) ecnts++;
            end
            ntot++;
            if (bit_valid !== ev[c]) $display("FAIL rnd_bv c=%0d: got %b want %b", c, bit_valid, ev[c]);
            else npass++;
            if (ev[c]) begin
                ntot++;
                if (bit_out !== eb[c]) $display("FAIL rnd_bit c=%0d: got %b want %b", c, bit_out, eb[c]);
                else npass++;
            end
            ntot++;
            if (detected !== ed[c]) $display("FAIL rnd_det c=%0d: got %b want %b", c, detected, ed[c]);
            else npass++;
            ntot++;
            if (int'(match_count) !== ecnt || int'(match_count_s) !== ecnts)
                $display("FAIL rnd_cnt c=%0d: got %0d/%0d want %0d/%0d", c, match_count, match_count_s, ecnt, ecnts);
            else npass++;
            ntot++;
            if (irq !== eirq) $display("FAIL rnd_irq c=%0d: got %b want %b", c, irq, eirq);
            else npass++;
            tick();
        end
        in_valid      = 1'b0;
        cfg_threshold = '0;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_back_to_back();
        test_threshold();
        test_fill_guard();
        test_saturation();
        test_clear_priority();
        test_enable_drop();
        test_reset_midword();
        for (int r = 0; r < 3; r++) test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
